// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 cipher core. Each cycle it computes one full encrypt
// or decrypt round, and it fetches the round key for that cycle by index.
module aes_cipher_core #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  input  logic         key_ready,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [3:0] NR = (KEY_BITS == 128) ? 4'd10 : (KEY_BITS == 192) ? 4'd12 : 4'd14;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_cipher_core: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  state_t       state_reg, state_next;
  logic [127:0] st_reg, st_next;
  logic [3:0]   rnd_reg, rnd_next;
  logic         dec_reg, dec_next;
  logic         accept, last_round;
  logic [127:0] enc_sb, enc_mc, enc_round;
  logic [127:0] dec_isb, dec_ark, dec_imc, dec_round;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128. This maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  // Circulant column mix: coefficients {02,03,01,01} forward, {0e,0b,0d,09} inverse.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0]  a [4];
    logic [7:0]  m0, m1, m2, m3;
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    m0 = inv ? 8'h0e : 8'h02;
    m1 = inv ? 8'h0b : 8'h03;
    m2 = inv ? 8'h0d : 8'h01;
    m3 = inv ? 8'h09 : 8'h01;
    o  = '0;
    for (int i = 0; i < 4; i++) begin
      o[31-8*i -: 8] = gmul(m0, a[2'(i)]) ^ gmul(m1, a[2'(i + 1)]) ^
                       gmul(m2, a[2'(i + 2)]) ^ gmul(m3, a[2'(i + 3)]);
    end
    return o;
  endfunction

  // Byte gi sits at row gi%4 and column gi/4. The shift rows step is folded into which source byte feeds each S-box.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R       = gi % 4;
    localparam int C       = gi / 4;
    localparam int ENC_SRC = R + 4 * ((C + R) % 4);
    localparam int DEC_SRC = R + 4 * ((C + 4 - R) % 4);
    assign enc_sb[127-8*gi -: 8]  = sbox(st_reg[127-8*ENC_SRC -: 8]);
    assign dec_isb[127-8*gi -: 8] = inv_sbox(st_reg[127-8*DEC_SRC -: 8]);
  end

  assign dec_ark = dec_isb ^ round_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign enc_mc[127-32*gi -: 32]  = mix_col(enc_sb[127-32*gi -: 32], 1'b0);
    assign dec_imc[127-32*gi -: 32] = mix_col(dec_ark[127-32*gi -: 32], 1'b1);
  end

  assign last_round = dec_reg ? (rnd_reg == 4'd0) : (rnd_reg == NR);
  assign enc_round  = (last_round ? enc_sb : enc_mc) ^ round_key;
  assign dec_round  = last_round ? dec_ark : dec_imc;

  assign in_ready = ~rst & key_ready & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      rnd_reg   <= '0;
      dec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      rnd_reg   <= rnd_next;
      dec_reg   <= dec_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = INIT;
      INIT:    if (key_ready) state_next = ROUND;
      ROUND:   if (key_ready && last_round) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? INIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // When key_ready is low, the round datapath holds its state and round counter.
  always_comb begin
    st_next  = st_reg;
    rnd_next = rnd_reg;
    dec_next = dec_reg;
    if (accept) begin
      st_next  = in_data;
      dec_next = in_decrypt;
      rnd_next = in_decrypt ? NR : 4'd0;
    end else if (key_ready && state_reg == INIT) begin
      st_next  = st_reg ^ round_key;
      rnd_next = dec_reg ? NR - 4'd1 : 4'd1;
    end else if (key_ready && state_reg == ROUND) begin
      st_next  = dec_reg ? dec_round : enc_round;
      rnd_next = dec_reg ? rnd_reg - 4'd1 : rnd_reg + 4'd1;
    end
  end

  always_comb begin
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
    out_data  = (state_reg == DONE) ? st_reg : '0;
    round_idx = (state_reg == INIT || state_reg == ROUND) ? rnd_reg : 4'd0;
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core. It drives one core per key size against FIPS-197 vectors.
// Expected blocks go through a scoreboard queue.
module tb_aes_cipher_core;
  logic         clk, rst;
  logic         in_valid [3];
  logic         in_ready [3];
  logic [127:0] in_data;
  logic         in_decrypt, key_ready, out_ready;
  logic [3:0]   round_idx_w [3];
  logic [127:0] round_key_w [3];
  logic         out_valid [3];
  logic [127:0] out_data [3];
  logic         busy [3];

  logic [127:0] sched [3][16];
  logic [7:0]   sbox_t [256];
  logic [3:0]   idx_log [64];
  logic [127:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign round_key_w[gi] = sched[gi][round_idx_w[gi]];
    aes_cipher_core #(.KEY_BITS(128 + 64 * gi)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .in_data(in_data), .in_decrypt(in_decrypt),
      .key_ready(key_ready), .round_idx(round_idx_w[gi]), .round_key(round_key_w[gi]),
      .out_valid(out_valid[gi]), .out_ready(out_ready),
      .out_data(out_data[gi]), .busy(busy[gi])
    );
  end

  function automatic logic [127:0] ct_of(input int k);
    return (k == 0) ? CT128 : (k == 1) ? CT192 : CT256;
  endfunction

  // Polynomial product followed by reduction modulo 0x11B
  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic expand_key(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * k;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = bmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      sched[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block, waits (bounded) for in_ready, and returns just after the acceptance edge.
  task automatic send_block(input int k, input logic [127:0] data, input logic dec, output bit ok);
    int n;
    n = 0;
    in_data = data;
    in_decrypt = dec;
    in_valid[k] = 1'b1;
    #1;
    while (!in_ready[k] && n < 50) begin
      tick();
      n++;
    end
    ok = in_ready[k];
    tick();
    in_valid[k] = 1'b0;
  endtask

  // Counts edges until out_valid (bounded) and logs round_idx for each cycle.
  task automatic wait_out(input int k, output int n, output logic [127:0] data, output bit to);
    n = 0;
    while (!out_valid[k] && n < 64) begin
      idx_log[n] = round_idx_w[k];
      tick();
      n++;
    end
    to = !out_valid[k];
    data = out_data[k];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid[0]); end
    checks++; if (out_data[0] !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data[0]); end
    checks++; if (round_idx_w[0] !== 4'd0) begin errors++; $display("FAIL reset_round_idx: got %0d required 0", round_idx_w[0]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy[2]); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b required 1", in_ready[0]); end
    key_ready = 1'b0;
    in_data = PT;
    in_valid[0] = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL idle_keyless_in_ready: got %b required 0", in_ready[0]); end
    tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL idle_keyless_accept: busy %b required 0", busy[0]); end
    in_valid[0] = 1'b0;
    key_ready = 1'b1;
  endtask

  task automatic test_encrypt(input int k);
    logic [127:0] got, exp;
    int n, nr, bad;
    bit ok, to;
    nr = 10 + 2 * k;
    out_ready = 1'b1;
    exp_q.push_back(ct_of(k));
    send_block(k, PT, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enc%0d_accept: in_ready 0 required 1", k); end
    wait_out(k, n, got, to);
    checks++; if (to || n != nr + 1) begin errors++; $display("FAIL enc%0d_latency: got %0d edges required %0d", k, n, nr + 1); end
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL enc%0d_data: got %h required %h", k, got, exp); end
    bad = -1;
    for (int i = nr; i >= 0; i--) if (idx_log[i] !== 4'(i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL enc%0d_round_idx: step %0d got %0d required %0d", k, bad, idx_log[bad], bad); end
    $display("enc KEY_BITS=%0d pt=%h -> %h (%0d edges)", 128 + 64 * k, PT, got, n);
  endtask

  task automatic test_decrypt(input int k);
    logic [127:0] got, exp;
    int n, nr, bad;
    bit ok, to;
    nr = 10 + 2 * k;
    out_ready = 1'b1;
    exp_q.push_back(PT);
    send_block(k, ct_of(k), 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dec%0d_accept: in_ready 0 required 1", k); end
    wait_out(k, n, got, to);
    checks++; if (to || n != nr + 1) begin errors++; $display("FAIL dec%0d_latency: got %0d edges required %0d", k, n, nr + 1); end
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL dec%0d_data: got %h required %h", k, got, exp); end
    bad = -1;
    for (int i = nr; i >= 0; i--) if (idx_log[i] !== 4'(nr - i)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL dec%0d_round_idx: step %0d got %0d required %0d", k, bad, idx_log[bad], nr - bad); end
    $display("dec KEY_BITS=%0d ct=%h -> %h (%0d edges)", 128 + 64 * k, ct_of(k), got, n);
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [4];
    logic [127:0] expv [4];
    logic [127:0] exp;
    int sent, recv, cyc, last_acc;
    blk[0] = PT;    expv[0] = CT128;
    blk[1] = CT128; expv[1] = PT;
    blk[2] = PT;    expv[2] = CT128;
    blk[3] = CT128; expv[3] = PT;
    sent = 0; recv = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while (recv < 4 && cyc < 200) begin
      if (sent < 4) begin
        in_valid[0] = 1'b1;
        in_data = blk[sent];
        in_decrypt = (sent % 2) == 1;
      end else begin
        in_valid[0] = 1'b0;
      end
      #1;
      if (in_valid[0] && in_ready[0]) begin
        exp_q.push_back(expv[sent]);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 12) begin errors++; $display("FAIL b2b_interval: got %0d cycles required 12", cyc - last_acc); end
        end
        $display("b2b accept block %0d decrypt=%0d at cycle %0d", sent, sent % 2, cyc);
        last_acc = cyc;
        sent++;
      end
      if (out_valid[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got %h required no output", out_data[0]);
        end else begin
          exp = exp_q.pop_front();
          if (out_data[0] !== exp) begin errors++; $display("FAIL b2b_data: got %h required %h", out_data[0], exp); end
        end
        recv++;
      end
      tick();
      cyc++;
    end
    in_valid[0] = 1'b0;
    checks++; if (sent != 4 || recv != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: sent %0d recv %0d pending %0d required 4 4 0", sent, recv, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] got, exp;
    int n, bad_data, bad_rdy;
    bit ok, to;
    out_ready = 1'b0;
    exp_q.push_back(CT128);
    send_block(0, PT, 1'b0, ok);
    wait_out(0, n, got, to);
    exp = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: out_valid 0 required 1"); end
    bad_data = 0; bad_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0] !== 1'b1 || out_data[0] !== exp) bad_data++;
      if (in_ready[0] !== 1'b0) bad_rdy++;
      tick();
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, out_data %h required %h", bad_data, out_data[0], exp); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL bp_in_ready: high in %0d cycles required 0", bad_rdy); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready[0]); end
    tick();
    checks++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release: out_valid %b busy %b required 0 0", out_valid[0], busy[0]);
    end
    $display("backpressure held %h for 20 cycles", exp);
  endtask

  task automatic test_key_stall();
    logic [127:0] got, exp;
    int n, bad;
    bit ok, stalled;
    out_ready = 1'b1;
    exp_q.push_back(CT128);
    send_block(0, PT, 1'b0, ok);
    n = 0; stalled = 1'b0; bad = 0;
    while (!out_valid[0] && n < 100) begin
      if (!stalled && round_idx_w[0] == 4'd5) begin
        key_ready = 1'b0;
        stalled = 1'b1;
        repeat (3) begin
          tick();
          n++;
          if (round_idx_w[0] !== 4'd5) bad++;
        end
        key_ready = 1'b1;
      end
      tick();
      n++;
    end
    got = out_data[0];
    exp = exp_q.pop_front();
    checks++; if (!stalled || bad != 0) begin errors++; $display("FAIL stall_round_idx: stalled %b, %0d cycles off round 5, required 1 0", stalled, bad); end
    checks++; if (n != 14) begin errors++; $display("FAIL stall_latency: got %0d edges required 14", n); end
    checks++; if (got !== exp) begin errors++; $display("FAIL stall_data: got %h required %h", got, exp); end
    $display("key stall result %h after %0d edges", got, n);
  endtask

  task automatic test_async_reset();
    logic [127:0] got, exp;
    int n;
    bit ok, to;
    out_ready = 1'b1;
    send_block(0, PT, 1'b0, ok);
    n = 0;
    while (round_idx_w[0] != 4'd4 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (round_idx_w[0] !== 4'd4) begin errors++; $display("FAIL arst_reach: round_idx %0d required 4", round_idx_w[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || round_idx_w[0] !== 4'd0) begin
      errors++; $display("FAIL arst_immediate: out_valid %b busy %b round_idx %0d required 0 0 0", out_valid[0], busy[0], round_idx_w[0]);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready[0] !== key_ready || busy[0] !== 1'b0) begin
      errors++; $display("FAIL arst_release: in_ready %b busy %b required %b 0", in_ready[0], busy[0], key_ready);
    end
    exp_q.push_back(CT128);
    send_block(0, PT, 1'b0, ok);
    wait_out(0, n, got, to);
    exp = exp_q.pop_front();
    checks++; if (to || got !== exp || n != 11) begin
      errors++; $display("FAIL arst_next_block: got %h after %0d edges required %h after 11", got, n, exp);
    end
    $display("post-reset block %h after %0d edges", got, n);
  endtask

  initial begin
    rst = 1'b0;
    key_ready = 1'b1;
    out_ready = 1'b1;
    in_data = '0;
    in_decrypt = 1'b0;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    build_sbox();
    expand_key(0, KEY128);
    expand_key(1, KEY192);
    expand_key(2, KEY256);
    test_reset();
    test_encrypt(0);
    test_decrypt(0);
    test_encrypt(1);
    test_decrypt(1);
    test_encrypt(2);
    test_decrypt(2);
    test_back_to_back();
    test_backpressure();
    test_key_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES block cipher core, parametrised over key length (AES-128/192/256) and supporting both encryption and decryption, selected per block. It sits between the host-side data path and the key-expansion block. It requests one round key per cycle by index and processes one full round per cycle. Blocks enter and leave through valid/ready handshakes, so upstream FIFOs and downstream consumers can stall it.

## Interface
Parameters:
- KEY_BITS, 128, key length. Only 128, 192 or 256 are legal; any other value is an elaboration error. NR = 10 / 12 / 14 respectively.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input block valid.
- in_ready  out  1  core can accept a block.
- in_data  in  128  plaintext (encrypt) or ciphertext (decrypt). FIPS-197 byte order: byte 0 = [127:120], column c = [127-32c -: 32].
- in_decrypt  in  1  mode for this block: 0 = encrypt, 1 = decrypt. Sampled on acceptance.
- key_ready  in  1  key schedule is valid for all indices.
- round_idx  out  4  round key index requested this cycle.
- round_key  in  128  key for round_idx, valid in the same cycle (combinational lookup).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result block.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, INIT, ROUND, DONE. Registers: st[127:0], rnd[3:0], dec.
- Acceptance: in_valid & in_ready at a clock edge.
  - st <= in_data, dec <= in_decrypt.
  - rnd <= 0 for encrypt, NR for decrypt.
  - Next state is INIT.
- in_ready = key_ready & (IDLE | (DONE & out_ready)). This gives zero-bubble back-to-back blocks.
- round_idx = rnd in INIT and ROUND; 0 otherwise.
- INIT: st <= st ^ round_key.
  - Encrypt: rnd <= 1. Decrypt: rnd <= NR-1.
  - Next state is ROUND.
- ROUND, encrypt:
  - Non-final round: st <= MixColumns(ShiftRows(SubBytes(st))) ^ round_key.
  - Final round (rnd == NR): MixColumns is omitted.
  - rnd increments each round. Leave for DONE after rnd == NR.
- ROUND, decrypt (straight inverse cipher):
  - Non-final round: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ round_key).
  - Final round (rnd == 0): InvMixColumns is omitted.
  - rnd decrements each round. Leave for DONE after rnd == 0.
- Stall on key: if key_ready is low in INIT or ROUND, st, rnd and state hold, and round_idx stays stable.
- DONE:
  - out_valid = 1 and out_data = st.
  - out_data is held stable until out_ready.
  - On out_ready: go to IDLE, or to INIT if a new block is accepted in the same edge.
- SubBytes and InvSubBytes are implemented as 16 parallel combinational byte lookups. GF(2^8) arithmetic uses reduction polynomial 0x11B.
- All round datapaths are combinational between st and its register. No other pipeline registers are used.

## Timing
- Reset values: in_ready 0 (forced while rst is high), out_valid 0, out_data 0, round_idx 0, busy 0, state IDLE, st 0.
- Latency: out_valid rises NR+1 clock edges after the acceptance edge when key_ready stays high. This is 11 / 13 / 15 edges for the three key sizes.
- Extra latency: each cycle with key_ready low in INIT or ROUND adds exactly one cycle.
- Throughput:
  - With out_ready held high: one block per NR+2 cycles.
  - With out_ready low: DONE holds indefinitely and in_ready = 0.
- Mode change between consecutive blocks takes effect at the next acceptance, with no extra cycle.
- Reset asserted mid-block: all registers clear asynchronously and the block is discarded. After release, the core is in IDLE with in_ready = key_ready.
- in_valid while busy and not in DONE-with-out_ready: the input is ignored (in_ready = 0), and in_data is not sampled.
- key_ready low while in IDLE: in_ready = 0, so no acceptance occurs.

## Test plan
- AES-128 encrypt, FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 edges after acceptance, round_idx sequence 0,1,…,10.
- AES-192 and AES-256 encrypt plus decrypt:
  - Stimulus: C.2 and C.3 keys with the same plaintext.
  - Required ciphertexts: dda97ca4864cdfe06eaf70a0ec0d7191 (AES-192) and 8ea2b7ca516745bfeafc49904b496089 (AES-256).
  - Decrypting each ciphertext returns 00112233445566778899aabbccddeeff. Decrypt round_idx sequence is NR, NR-1, …, 0.
- Back-to-back with mixed modes:
  - Stimulus: out_ready tied high; alternate encrypt and decrypt blocks with in_valid held high.
  - Required: acceptances every NR+2 cycles, each result correct, no lost or duplicated block.
- Backpressure:
  - Stimulus: hold out_ready low 20 cycles after out_valid rises.
  - Required: out_data stable, in_ready 0 throughout, then release after one out_ready cycle.
- Key stall:
  - Stimulus: drop key_ready for 3 cycles during round 5 of AES-128.
  - Required: round_idx holds at 5, result still 69c4…c55a, latency 14 edges.
- Asynchronous reset mid-block:
  - Stimulus: assert rst between edges during round 4.
  - Required: out_valid, busy and round_idx go to 0 immediately, without waiting for a clock edge. After release, the next block encrypts correctly.
